// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory responder
package mem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} t_mem_state;
   localparam int DATA_W    = 32;
   localparam int NUM_LANES = 4;
endpackage

// File: rtl/sram_1rw_be.sv
// rtl/sram_1rw_be.sv - synchronous single-port RAM with byte-enable write
module sram_1rw_be #(
   parameter int DEPTH_WORDS = 1024,
   parameter int DATA_W      = 32
) (
   input  logic                           clk,
   input  logic                           en,
   input  logic                           we,
   input  logic [3:0]                     be,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [DATA_W-1:0]              wdata,
   output logic [DATA_W-1:0]              rdata
);
   import mem_pkg::*;

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

   // rdata only changes on an enabled read, so it holds through backpressure
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int k = 0; k < NUM_LANES; k++) begin
               if (be[k]) mem_q[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
         end else begin
            rdata <= mem_q[addr];
         end
      end
   end
endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word memory responder with valid/ready request and response
module mem_responder #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic              clk,
   input  logic              arstn,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   input  logic [3:0]        i_req_wstrb,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_rsp_err
);
   import mem_pkg::*;

   localparam int              AW       = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W:0] LIMIT    = (ADDR_W+1)'(DEPTH_WORDS) << 2;
   localparam logic [3:0]      CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   t_mem_state             state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic                   rsp_err_q, rsp_err_d;
   logic                   rd_ok_q, rd_ok_d;
   logic                   we_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [DATA_W-1:0]      wdata_q;
   logic [NUM_LANES-1:0]   wstrb_q;
   logic                   fire;
   logic                   src_we, src_err;
   logic [ADDR_W-1:0]      src_addr;
   logic [DATA_W-1:0]      src_wdata;
   logic [NUM_LANES-1:0]   src_wstrb;
   logic [DATA_W-1:0]      ram_rdata;

   // With LATENCY==1 the RAM is accessed in the accept cycle, straight from the request inputs
   assign src_we    = (state_q == IDLE) ? i_req_we    : we_q;
   assign src_addr  = (state_q == IDLE) ? i_req_addr  : addr_q;
   assign src_wdata = (state_q == IDLE) ? i_req_wdata : wdata_q;
   assign src_wstrb = (state_q == IDLE) ? i_req_wstrb : wstrb_q;
   assign src_err   = (|src_addr[1:0]) || ({1'b0, src_addr} >= LIMIT);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rd_ok_d     = rd_ok_q;
      fire        = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_req_valid) begin
               if (LATENCY == 1) begin
                  fire = 1'b1;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) fire = 1'b1;
            else               cnt_d = cnt_q - 4'd1;
         end
         RESP: begin
            if (i_rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rd_ok_d     = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (fire) begin
         state_d     = RESP;
         rsp_valid_d = 1'b1;
         rsp_err_d   = src_err;
         rd_ok_d     = !src_we && !src_err;
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rd_ok_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rd_ok_q     <= rd_ok_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == IDLE && i_req_valid) begin
         we_q    <= i_req_we;
         addr_q  <= i_req_addr;
         wdata_q <= i_req_wdata;
         wstrb_q <= i_req_wstrb;
      end
   end

   sram_1rw_be #(.DEPTH_WORDS(DEPTH_WORDS), .DATA_W(DATA_W)) u_sram (
      .clk   (clk),
      .en    (fire && !src_err),
      .we    (src_we),
      .be    (src_wstrb),
      .addr  (src_addr[AW+1:2]),
      .wdata (src_wdata),
      .rdata (ram_rdata)
   );

   assign o_req_ready = (state_q == IDLE);
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_err   = rsp_err_q;
   assign o_rsp_rdata = ram_rdata & {DATA_W{rd_ok_q}};
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder at LATENCY 2 and 1
module tb_mem_responder;
   logic clk = 1'b0;
   logic arstn;

   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_wstrb [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   vec_t tbl[$];
   logic [7:0] mb [64];

   always #5 clk = ~clk;

   mem_responder #(.LATENCY(2)) u_lat2 (
      .clk(clk), .arstn(arstn),
      .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_we(req_we[0]),
      .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]), .i_req_wstrb(req_wstrb[0]),
      .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
      .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0])
   );

   mem_responder #(.LATENCY(1)) u_lat1 (
      .clk(clk), .arstn(arstn),
      .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_we(req_we[1]),
      .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]), .i_req_wstrb(req_wstrb[1]),
      .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
      .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1])
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic vec_t mk(bit we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb,
                               logic [31:0] exp_rdata, bit exp_err);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic do_req(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, output logic [31:0] rdata, output logic err,
                         output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!req_ready[d] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_wstrb[d] = wstrb;
      @(negedge clk);
      req_valid[d] = 1'b0;
      lat = 1;
      while (!rsp_valid[d] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rdata = rsp_rdata[d];
      err   = rsp_err[d];
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
   endtask

   function automatic logic [31:0] model_word(int w);
      return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
   endfunction

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;

      arstn = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
         req_wdata[d] = '0;   req_wstrb[d] = '0; rsp_ready[d] = 1'b0;
      end

      tbl.push_back(mk(1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        0));
      tbl.push_back(mk(0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 0));
      tbl.push_back(mk(1, 32'h20,   32'h11223344, 4'hF, 32'h0,        0));
      tbl.push_back(mk(1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        0));
      tbl.push_back(mk(0, 32'h20,   32'h0,        4'hF, 32'h11BB33DD, 0));
      tbl.push_back(mk(0, 32'h6,    32'h0,        4'hF, 32'h0,        1));
      tbl.push_back(mk(1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h0,        0));
      tbl.push_back(mk(1, 32'h4000, 32'h12345678, 4'hF, 32'h0,        1));
      tbl.push_back(mk(1, 32'h2,    32'h87654321, 4'hF, 32'h0,        1));
      tbl.push_back(mk(0, 32'h0,    32'h0,        4'hF, 32'hCAFEF00D, 0));
      tbl.push_back(mk(1, 32'h24,   32'h55667788, 4'hF, 32'h0,        0));
      tbl.push_back(mk(1, 32'h24,   32'hFFFFFFFF, 4'h0, 32'h0,        0));
      tbl.push_back(mk(0, 32'h24,   32'h0,        4'hF, 32'h55667788, 0));
      tbl.push_back(mk(1, 32'hFFC,  32'h13579BDF, 4'hF, 32'h0,        0));
      tbl.push_back(mk(0, 32'hFFC,  32'h0,        4'hF, 32'h13579BDF, 0));
      tbl.push_back(mk(0, 32'h1000, 32'h0,        4'hF, 32'h0,        1));

      repeat (3) @(negedge clk);
      check("reset_req_ready", 32'(req_ready[0]), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      check("reset_rsp_rdata", rsp_rdata[0],     32'd0);
      check("reset_rsp_err",   32'(rsp_err[0]),   32'd0);
      arstn = 1'b1;

      foreach (tbl[i]) begin
         do_req(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, rd, er, lat);
         check($sformatf("tbl%0d_lat", i),   32'(lat), 32'd2);
         check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
         check($sformatf("tbl%0d_err", i),   32'(er), 32'(tbl[i].exp_err));
      end

      // Backpressure: response held while a competing write request is presented
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10; req_wstrb[0] = 4'hF;
      @(negedge clk);
      req_we[0] = 1'b1; req_wdata[0] = 32'h0BADF00D;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
         check("bp_rsp_rdata", rsp_rdata[0],      32'hDEADBEEF);
         check("bp_req_ready", 32'(req_ready[0]), 32'd0);
         @(negedge clk);
      end
      req_valid[0] = 1'b0;
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      rsp_ready[0] = 1'b0;
      check("bp_after_valid", 32'(rsp_valid[0]), 32'd0);
      check("bp_after_rdata", rsp_rdata[0],      32'd0);
      check("bp_after_ready", 32'(req_ready[0]), 32'd1);
      do_req(0, 0, 32'h10, 32'h0, 4'hF, rd, er, lat);
      check("bp_no_write", rd, 32'hDEADBEEF);

      // Reset during WAIT of a write must not commit it
      do_req(0, 1, 32'h40, 32'h01020304, 4'hF, rd, er, lat);
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h40;
      req_wdata[0] = 32'hAAAAAAAA; req_wstrb[0] = 4'hF;
      @(negedge clk);
      req_valid[0] = 1'b0;
      arstn = 1'b0;
      repeat (2) @(negedge clk);
      arstn = 1'b1;
      check("rst_mid_valid", 32'(rsp_valid[0]), 32'd0);
      check("rst_mid_ready", 32'(req_ready[0]), 32'd1);
      do_req(0, 0, 32'h40, 32'h0, 4'hF, rd, er, lat);
      check("rst_mid_old", rd, 32'h01020304);

      // LATENCY=1: fill 16 words, then random traffic against a byte-level model
      for (int w = 0; w < 16; w++) begin
         logic [31:0] v;
         v = $urandom;
         for (int b = 0; b < 4; b++) mb[4*w+b] = v[8*b +: 8];
         do_req(1, 1, 32'(4*w), v, 4'hF, rd, er, lat);
         check("l1_fill_lat", 32'(lat), 32'd1);
         check("l1_fill_err", 32'(er),  32'd0);
      end
      for (int n = 0; n < 100; n++) begin
         bit          we;
         int          w;
         logic [31:0] v;
         logic [3:0]  s;
         logic [31:0] exp;
         we = 1'($urandom_range(0, 1));
         w  = int'($urandom_range(0, 15));
         v  = $urandom;
         s  = 4'($urandom_range(0, 15));
         exp = we ? 32'h0 : model_word(w);
         if (we) begin
            for (int b = 0; b < 4; b++) if (s[b]) mb[4*w+b] = v[8*b +: 8];
         end
         do_req(1, we, 32'(4*w), v, s, rd, er, lat);
         check($sformatf("l1_rand%0d_lat", n),   32'(lat), 32'd1);
         check($sformatf("l1_rand%0d_rdata", n), rd,       exp);
         check($sformatf("l1_rand%0d_err", n),   32'(er),  32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
